// File: rtl/sram_controller.sv
// Bridge from the cache controller's request port to a 256Kx16 asynchronous SRAM.
// Reads fetch a 64-bit block in four beats; writes store one 32-bit word in two beats.
module sram_controller #(
  parameter int BEAT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] address,
  input  logic [31:0] wdata,
  input  logic        read,
  input  logic        write,
  output logic [63:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [2:0] CYC_LAST = 3'(BEAT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [1:0]  beat_reg, beat_next;
  logic [2:0]  cyc_reg, cyc_next;
  logic [17:2] addr_reg;
  logic [31:0] wdata_reg;
  logic [47:0] rd_buf;
  logic [63:0] rdata_reg;
  logic        ready_reg;
  logic [17:0] sram_addr_reg, sram_addr_next;
  logic        we_n_reg, oe_n_reg, ce_n_reg, dq_oe_reg;
  logic [15:0] dq_out_reg, dq_out_next;

  logic [17:2] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  last_beat;
  logic        beat_end;
  logic        unused_addr_bits;

  // The word is always 4-byte aligned, so the low address bits carry nothing.
  assign unused_addr_bits = ^address[1:0];

  assign beat_end  = (cyc_reg == CYC_LAST);
  assign last_beat = (state_reg == S_READ) ? 2'd3 : 2'd1;

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    cyc_next   = cyc_reg;
    req_addr   = addr_reg;
    req_wdata  = wdata_reg;
    case (state_reg)
      S_IDLE: begin
        req_addr  = address[17:2];
        req_wdata = wdata;
        beat_next = 2'd0;
        cyc_next  = 3'd0;
        if (write)
          state_next = S_WRITE;
        else if (read)
          state_next = S_READ;
      end
      S_READ, S_WRITE: begin
        if (beat_end) begin
          cyc_next = 3'd0;
          if (beat_reg == last_beat) begin
            state_next = S_DONE;
            beat_next  = 2'd0;
          end else begin
            beat_next = beat_reg + 2'd1;
          end
        end else begin
          cyc_next = cyc_reg + 3'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        beat_next  = 2'd0;
        cyc_next   = 3'd0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they come straight out of flops.
  always_comb begin
    sram_addr_next = 18'd0;
    if (state_next == S_READ)
      sram_addr_next = {1'b0, req_addr[17:3], beat_next};
    else if (state_next == S_WRITE)
      sram_addr_next = {1'b0, req_addr[17:2], beat_next[0]};
    dq_out_next = beat_next[0] ? req_wdata[31:16] : req_wdata[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      beat_reg      <= 2'd0;
      cyc_reg       <= 3'd0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      ready_reg     <= 1'b0;
      sram_addr_reg <= '0;
      we_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      ce_n_reg      <= 1'b1;
      dq_oe_reg     <= 1'b0;
      dq_out_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      cyc_reg       <= cyc_next;
      if (state_reg == S_IDLE && state_next != S_IDLE) begin
        addr_reg  <= address[17:2];
        wdata_reg <= wdata;
      end
      if (state_reg == S_READ && beat_end && beat_reg == 2'd3)
        rdata_reg <= {SRAM_DQ, rd_buf};
      ready_reg     <= (state_next == S_DONE);
      sram_addr_reg <= sram_addr_next;
      we_n_reg      <= !(state_next == S_WRITE && cyc_next != 3'd0);
      oe_n_reg      <= !(state_next == S_READ);
      ce_n_reg      <= !(state_next == S_READ || state_next == S_WRITE);
      dq_oe_reg     <= (state_next == S_WRITE);
      dq_out_reg    <= dq_out_next;
    end
  end

  // Beats 0..2 are staged here so rdata only changes when the whole block is in.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic [15:0] lane_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lane_reg <= '0;
        else if (state_reg == S_READ && beat_end && beat_reg == 2'(gi))
          lane_reg <= SRAM_DQ;
      end
      assign rd_buf[16*gi +: 16] = lane_reg;
    end
  endgenerate

  assign rdata     = rdata_reg;
  assign ready     = ready_reg;
  assign SRAM_ADDR = sram_addr_reg;
  assign SRAM_WE_N = we_n_reg;
  assign SRAM_OE_N = oe_n_reg;
  assign SRAM_CE_N = ce_n_reg;
  assign SRAM_UB_N = ce_n_reg;
  assign SRAM_LB_N = ce_n_reg;
  assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'hzzzz;

endmodule
